// File: rtl/pipe_ctrl_unit_if.sv
// Bundle between the pipeline datapath and pipe_ctrl_unit.
// ID-stage fields and EX-stage status flow into the control unit (slave);
// hazard controls, EX/MEM/WB control outputs flow back to the datapath (master).
//   opcode/funct3/funct7/rs1_id/rs2_id/rd_id : ID-stage instruction fields
//   branch_taken, addr_lo                    : EX-stage status
//   stall_out, flush_out                     : PC / IF-ID hold and squash
//   alu_ctrl, mul_sel, mux3_sel, mux4_sel    : EX controls
//   DM_WEB, DM_BWEB, misalign                : MEM store controls (active-low enables)
//   wb_en, wb_rd                             : WB register write
interface pipe_ctrl_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  localparam int unsigned AW = $clog2(XLEN / 8);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RA_W-1:0] rs1_id;
  logic [RA_W-1:0] rs2_id;
  logic [RA_W-1:0] rd_id;
  logic            branch_taken;
  logic [AW-1:0]   addr_lo;

  logic            stall_out;
  logic            flush_out;
  logic [3:0]      alu_ctrl;
  logic            mul_sel;
  logic            mux3_sel;
  logic            mux4_sel;
  logic            DM_WEB;
  logic [XLEN-1:0] DM_BWEB;
  logic            misalign;
  logic            wb_en;
  logic [RA_W-1:0] wb_rd;

  modport master (
    output opcode, funct3, funct7, rs1_id, rs2_id, rd_id, branch_taken, addr_lo,
    input  stall_out, flush_out, alu_ctrl, mul_sel, mux3_sel, mux4_sel,
    input  DM_WEB, DM_BWEB, misalign, wb_en, wb_rd
  );

  modport slave (
    input  opcode, funct3, funct7, rs1_id, rs2_id, rd_id, branch_taken, addr_lo,
    output stall_out, flush_out, alu_ctrl, mul_sel, mux3_sel, mux4_sel,
    output DM_WEB, DM_BWEB, misalign, wb_en, wb_rd
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: decodes the ID-stage instruction, carries its controls
// through ID/EX, EX/MEM and MEM/WB registers, and resolves load-use stalls,
// multi-cycle multiply holds and control-flow flushes.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, loads bubbles everywhere
//   ctrl_io : pipe_ctrl_unit_if slave (ID fields in, EX status in, controls out)
module pipe_ctrl_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned MUL_LAT = 3
) (
  input logic             clk,
  input logic             rst,
  pipe_ctrl_unit_if.slave ctrl_io
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned AW   = $clog2(NB);
  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_LAT - 1);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef struct packed {
    logic [3:0]      alu;
    logic            mul;
    logic            mux3;
    logic            mux4;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic [1:0]      size;      // store access size, log2 bytes
    logic            wb_en;
    logic [RA_W-1:0] rd;        // zero unless wb_en
  } idex_t;

  typedef struct packed {
    logic            web;
    logic [XLEN-1:0] bweb;
    logic            mis;
    logic            wb_en;
    logic [RA_W-1:0] rd;
  } exmem_t;

  localparam idex_t  IdexBubble  = '0;
  localparam exmem_t ExmemBubble = '{web: 1'b1, bweb: '1, mis: 1'b0, wb_en: 1'b0, rd: '0};

  idex_t           dec, idex_d, idex_q;
  exmem_t          exmem_d, exmem_q;
  logic            wb_en_q;
  logic [RA_W-1:0] wb_rd_q;
  logic [CntW-1:0] mul_cnt_d, mul_cnt_q;
  logic            known, uses_rs2, flush, mul_hold, load_use;
  int unsigned     size_log;
  logic [AW-1:0]   lane_mask;

  // ID-stage decode
  always_comb begin
    dec   = IdexBubble;
    known = 1'b1;
    case (ctrl_io.opcode)
      OpR: begin
        if (ctrl_io.funct7 == 7'b0000001) dec.mul = 1'b1;
        else                              dec.alu = {ctrl_io.funct7[5], ctrl_io.funct3};
      end
      OpI: begin
        dec.mux4 = 1'b1;
        // Only shifts take funct7[5]; for the rest those bits are immediate.
        if (ctrl_io.funct3 == 3'b001 || ctrl_io.funct3 == 3'b101) begin
          dec.alu = {ctrl_io.funct7[5], ctrl_io.funct3};
        end else begin
          dec.alu = {1'b0, ctrl_io.funct3};
        end
      end
      OpLoad: begin
        dec.mux4    = 1'b1;
        dec.is_load = 1'b1;
      end
      OpStore: begin
        dec.mux4     = 1'b1;
        dec.is_store = 1'b1;
        dec.size     = ctrl_io.funct3[1:0];
      end
      OpBranch: dec.is_branch = 1'b1;
      OpJal: begin
        dec.mux3    = 1'b1;
        dec.mux4    = 1'b1;
        dec.is_jump = 1'b1;
      end
      OpJalr: begin
        dec.mux4    = 1'b1;
        dec.is_jump = 1'b1;
      end
      OpAuipc: begin
        dec.mux3 = 1'b1;
        dec.mux4 = 1'b1;
      end
      OpLui: begin
        dec.mux4 = 1'b1;
        dec.alu  = 4'b1001;
      end
      default: known = 1'b0;
    endcase
    dec.wb_en = known && !dec.is_branch && !dec.is_store && (ctrl_io.rd_id != '0);
    dec.rd    = dec.wb_en ? ctrl_io.rd_id : '0;
  end

  // Hazards. A multiply occupies EX until the counter reaches MUL_LAT-1.
  always_comb begin
    uses_rs2 = (ctrl_io.opcode == OpR) || (ctrl_io.opcode == OpStore) ||
               (ctrl_io.opcode == OpBranch);
    flush    = idex_q.is_jump || (idex_q.is_branch && ctrl_io.branch_taken);
    mul_hold = idex_q.mul && (mul_cnt_q != CntLast);
    load_use = idex_q.is_load && (idex_q.rd != '0) &&
               ((idex_q.rd == ctrl_io.rs1_id) || (uses_rs2 && (idex_q.rd == ctrl_io.rs2_id)));
    mul_cnt_d = mul_hold ? mul_cnt_q + CntW'(1) : '0;

    if (flush)         idex_d = IdexBubble;
    else if (mul_hold) idex_d = idex_q;
    else if (load_use) idex_d = IdexBubble;
    else               idex_d = dec;
  end

  // EX -> MEM: store byte enables. Repeat cycles of a held multiply send bubbles.
  always_comb begin
    exmem_d   = ExmemBubble;
    size_log  = 0;
    lane_mask = '0;
    if (!(idex_q.mul && mul_cnt_q != '0)) begin
      exmem_d.wb_en = idex_q.wb_en;
      exmem_d.rd    = idex_q.rd;
      if (idex_q.is_store) begin
        size_log = 32'(idex_q.size);
        if (size_log > AW) size_log = AW;
        lane_mask = AW'((32'd1 << size_log) - 32'd1);
        if ((ctrl_io.addr_lo & lane_mask) != '0) begin
          exmem_d.mis = 1'b1;
        end else begin
          exmem_d.web = 1'b0;
          // A lane belongs to the access when it agrees with addr_lo above the size bits.
          for (int unsigned i = 0; i < NB; i++) begin
            if ((AW'(i) | lane_mask) == (ctrl_io.addr_lo | lane_mask)) begin
              exmem_d.bweb[8*i +: 8] = 8'h00;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q    <= IdexBubble;
      exmem_q   <= ExmemBubble;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      mul_cnt_q <= '0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      wb_en_q   <= exmem_q.wb_en;
      wb_rd_q   <= exmem_q.rd;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign ctrl_io.stall_out = !flush && (mul_hold || load_use);
  assign ctrl_io.flush_out = flush;
  assign ctrl_io.alu_ctrl  = idex_q.alu;
  assign ctrl_io.mul_sel   = idex_q.mul;
  assign ctrl_io.mux3_sel  = idex_q.mux3;
  assign ctrl_io.mux4_sel  = idex_q.mux4;
  assign ctrl_io.DM_WEB    = exmem_q.web;
  assign ctrl_io.DM_BWEB   = exmem_q.bweb;
  assign ctrl_io.misalign  = exmem_q.mis;
  assign ctrl_io.wb_en     = wb_en_q;
  assign ctrl_io.wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: decode vector table, hand-written
// hazard/reset sequences, and a randomized run against a reference model.
module tb_pipe_ctrl_unit;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned AW      = $clog2(XLEN / 8);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBad    = 7'b1111111;

  localparam logic [63:0] RstOuts = 64'({1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1,
                                         32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0});

  logic clk;
  logic rst;

  pipe_ctrl_unit_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  pipe_ctrl_unit #(.XLEN(XLEN), .RA_W(RA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.stall_out, bus.flush_out, bus.alu_ctrl, bus.mul_sel, bus.mux3_sel,
                bus.mux4_sel, bus.DM_WEB, bus.DM_BWEB, bus.misalign, bus.wb_en, bus.wb_rd});
  endfunction

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                        input logic [RA_W-1:0] rd);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rs1_id = rs1;
    bus.rs2_id = rs2;
    bus.rd_id  = rd;
  endtask

  task automatic nop_id();
    set_id(7'd0, 3'd0, 7'd0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop_id();
    bus.branch_taken = 1'b0;
    bus.addr_lo      = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [AW-1:0]   addr;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_age;

  function automatic logic is_known(input logic [6:0] op);
    return op inside {OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpAuipc, OpLui};
  endfunction

  function automatic logic is_mul(input ins_t i);
    return (i.op == OpR) && (i.f7 == 7'b0000001);
  endfunction

  function automatic logic [3:0] ref_alu(input ins_t i);
    if (i.op == OpR) return is_mul(i) ? 4'h0 : {i.f7[5], i.f3};
    if (i.op == OpI) return (i.f3 == 3'd1 || i.f3 == 3'd5) ? {i.f7[5], i.f3} : {1'b0, i.f3};
    if (i.op == OpLui) return 4'h9;
    return 4'h0;
  endfunction

  function automatic logic ref_wb(input ins_t i);
    return is_known(i.op) && i.op != OpBranch && i.op != OpStore && i.rd != '0;
  endfunction

  function automatic logic [63:0] ref_outs(input logic stall, input logic flush);
    logic            web;
    logic [XLEN-1:0] bweb;
    logic            mis;
    logic            m3, m4, wbe;
    int              size;
    web  = 1'b1;
    bweb = '1;
    mis  = 1'b0;
    if (m_mem.op == OpStore) begin
      size = 1 << m_mem.f3[1:0];
      if (int'(m_mem.addr) % size != 0) begin
        mis = 1'b1;
      end else begin
        web  = 1'b0;
        bweb = XLEN'(~(((64'd1 << (8 * size)) - 64'd1) << (8 * int'(m_mem.addr))));
      end
    end
    m3  = (m_ex.op == OpAuipc) || (m_ex.op == OpJal);
    m4  = is_known(m_ex.op) && m_ex.op != OpR && m_ex.op != OpBranch;
    wbe = ref_wb(m_wb);
    return 64'({stall, flush, ref_alu(m_ex), is_mul(m_ex), m3, m4, web, bweb, mis, wbe,
                wbe ? m_wb.rd : 5'd0});
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    logic [6:0] ops [10];
    ops = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpAuipc, OpLui, OpBad};
    i.op = ops[$urandom_range(0, 9)];
    i.f3 = (i.op == OpStore) ? 3'($urandom_range(0, 2)) : 3'($urandom);
    case ($urandom_range(0, 3))
      0:       i.f7 = 7'h00;
      1:       i.f7 = 7'h20;
      2:       i.f7 = 7'h01;
      default: i.f7 = 7'($urandom);
    endcase
    i.rd   = RA_W'($urandom_range(0, 3));
    i.rs1  = RA_W'($urandom_range(0, 3));
    i.rs2  = RA_W'($urandom_range(0, 3));
    i.addr = '0;
    return i;
  endfunction

  // ---------------- decode vector table ----------------
  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [1:0]  addr;
    logic [3:0]  alu;
    logic        mul;
    logic        m3;
    logic        m4;
    logic        web;
    logic [31:0] bweb;
    logic        mis;
    logic        wb;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  ins_t id_i;
  logic hold_id, mflush, mhold, mlu, mstall;
  logic [2:0] exp_c [6] = '{3'b110, 3'b110, 3'b011, 3'b000, 3'b000, 3'b001};

  initial begin
    tbl.push_back('{OpR,      3'd0, 7'h00, 5'd1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpR,      3'd0, 7'h20, 5'd2, 2'd0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpR,      3'd5, 7'h20, 5'd3, 2'd0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpR,      3'd0, 7'h01, 5'd4, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpI,      3'd0, 7'h20, 5'd5, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpI,      3'd5, 7'h20, 5'd6, 2'd0, 4'hD, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpI,      3'd4, 7'h7F, 5'd7, 2'd0, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpLoad,   3'd2, 7'h00, 5'd7, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpStore,  3'd0, 7'h00, 5'd0, 2'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFF00_FFFF, 1'b0, 1'b0});
    tbl.push_back('{OpStore,  3'd1, 7'h00, 5'd0, 2'd1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
    tbl.push_back('{OpStore,  3'd1, 7'h00, 5'd3, 2'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0});
    tbl.push_back('{OpStore,  3'd2, 7'h00, 5'd0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{OpStore,  3'd2, 7'h00, 5'd0, 2'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
    tbl.push_back('{OpBranch, 3'd0, 7'h00, 5'd9, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0});
    tbl.push_back('{OpJal,    3'd0, 7'h00, 5'd1, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpJalr,   3'd0, 7'h00, 5'd2, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpAuipc,  3'd0, 7'h00, 5'd3, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpLui,    3'd0, 7'h00, 5'd4, 2'd0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{OpBad,    3'd7, 7'h7F, 5'd5, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0});
    tbl.push_back('{OpR,      3'd0, 7'h00, 5'd0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0});

    rst = 1'b1;
    nop_id();
    bus.branch_taken = 1'b0;
    bus.addr_lo      = '0;
    #3;
    chk("reset_state", outs(), RstOuts);
    step();
    rst = 1'b0;

    // Decode table: instruction passes EX, MEM, WB with bubbles behind it.
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      do_reset();
      set_id(v.op, v.f3, v.f7, '0, '0, v.rd);
      step();
      nop_id();
      bus.addr_lo = v.addr;
      @(negedge clk);
      chk($sformatf("vec%0d_ex", k), {bus.alu_ctrl, bus.mul_sel, bus.mux3_sel, bus.mux4_sel},
          {v.alu, v.mul, v.m3, v.m4});
      step();
      @(negedge clk);
      chk($sformatf("vec%0d_mem", k), {bus.DM_WEB, bus.DM_BWEB, bus.misalign},
          {v.web, v.bweb, v.mis});
      step();
      @(negedge clk);
      chk($sformatf("vec%0d_wb", k), {bus.wb_en, bus.wb_rd}, {v.wb, v.wb ? v.rd : 5'd0});
    end

    // Load-use: lw x5 then add x6,x5,x0.
    do_reset();
    set_id(OpLoad, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5);
    step();
    set_id(OpR, 3'd0, 7'h00, 5'd5, 5'd0, 5'd6);
    @(negedge clk);
    chk("lu_stall", bus.stall_out, 1'b1);
    step();
    @(negedge clk);
    chk("lu_stall_once", bus.stall_out, 1'b0);
    step();
    nop_id();
    @(negedge clk);
    chk("lu_add_ex", {bus.alu_ctrl, bus.mul_sel, bus.mux4_sel}, 6'b0);
    chk("lu_wb_load", {bus.wb_en, bus.wb_rd}, {1'b1, 5'd5});
    step();
    @(negedge clk);
    chk("lu_wb_bubble", bus.wb_en, 1'b0);
    step();
    @(negedge clk);
    chk("lu_wb_add", {bus.wb_en, bus.wb_rd}, {1'b1, 5'd6});

    // Taken branch squashes the xori behind it.
    do_reset();
    set_id(OpBranch, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0);
    step();
    set_id(OpI, 3'd4, 7'h00, 5'd1, 5'd0, 5'd7);
    bus.branch_taken = 1'b1;
    @(negedge clk);
    chk("br_flush", {bus.flush_out, bus.stall_out}, 2'b10);
    step();
    nop_id();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("br_bubble_ex", {bus.flush_out, bus.alu_ctrl, bus.mux4_sel}, 6'b0);
    step();
    @(negedge clk);
    chk("br_wb", bus.wb_en, 1'b0);
    step();
    @(negedge clk);
    chk("br_wb_squashed", bus.wb_en, 1'b0);

    // Multiply then add: {stall, mul_sel, wb_en} per cycle.
    do_reset();
    set_id(OpR, 3'd0, 7'h01, 5'd1, 5'd2, 5'd8);
    step();
    for (int c = 0; c < 6; c++) begin
      if (c < 3) set_id(OpR, 3'd0, 7'h00, 5'd1, 5'd2, 5'd9);
      else       nop_id();
      @(negedge clk);
      chk($sformatf("mul_c%0d", c), {bus.stall_out, bus.mul_sel, bus.wb_en}, exp_c[c]);
      if (c == 2) chk("mul_wb_rd", bus.wb_rd, 5'd8);
      if (c == 5) chk("add_wb_rd", bus.wb_rd, 5'd9);
      step();
    end

    // Reset in the second multiply-hold cycle, then srai decodes normally.
    do_reset();
    set_id(OpR, 3'd0, 7'h01, 5'd1, 5'd2, 5'd8);
    step();
    set_id(OpR, 3'd0, 7'h00, 5'd1, 5'd2, 5'd9);
    step();
    chk("mul_hold2", {bus.stall_out, bus.mul_sel}, 2'b11);
    #1;
    rst = 1'b1;
    #1;
    chk("mul_async_rst", outs(), RstOuts);
    step();
    rst = 1'b0;
    set_id(OpI, 3'd5, 7'h20, 5'd1, 5'd0, 5'd3);
    step();
    nop_id();
    @(negedge clk);
    chk("srai_after_rst", {bus.stall_out, bus.alu_ctrl, bus.mul_sel, bus.mux4_sel},
        {1'b0, 4'hD, 1'b0, 1'b1});

    // Randomized run against the reference model.
    do_reset();
    m_ex    = '0;
    m_mem   = '0;
    m_wb    = '0;
    m_age   = 1;
    hold_id = 1'b0;
    id_i    = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!hold_id) id_i = rand_ins();
      set_id(id_i.op, id_i.f3, id_i.f7, id_i.rs1, id_i.rs2, id_i.rd);
      bus.branch_taken = 1'($urandom_range(0, 1));
      bus.addr_lo      = AW'($urandom);
      mflush = (m_ex.op == OpJal) || (m_ex.op == OpJalr) ||
               (m_ex.op == OpBranch && bus.branch_taken);
      mhold  = is_mul(m_ex) && (m_age < MUL_LAT);
      mlu    = (m_ex.op == OpLoad) && (m_ex.rd != '0) &&
               ((m_ex.rd == id_i.rs1) ||
                ((id_i.op inside {OpR, OpStore, OpBranch}) && m_ex.rd == id_i.rs2));
      mstall = !mflush && (mhold || mlu);
      @(negedge clk);
      chk($sformatf("rand%0d", c), outs(), ref_outs(mstall, mflush));
      @(posedge clk);
      m_wb = m_mem;
      if (is_mul(m_ex) && m_age > 1) begin
        m_mem = '0;
      end else begin
        m_mem      = m_ex;
        m_mem.addr = bus.addr_lo;
      end
      if (mflush) begin
        m_ex  = '0;
        m_age = 1;
      end else if (mhold) begin
        m_age++;
      end else if (mlu) begin
        m_ex  = '0;
        m_age = 1;
      end else begin
        m_ex  = id_i;
        m_age = 1;
      end
      hold_id = mstall;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width and DM_BWEB width (XLEN/8 byte lanes, XLEN in {32,64}).
REQ-002 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-003 SHALL have parameter MUL_LAT, default 3, meaning EX cycles occupied by a multiply (MUL_LAT >= 1).
REQ-004 SHALL have ports:
  clk  in  1  clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-high
  opcode  in  7  ID-stage opcode
  funct3  in  3  ID-stage funct3
  funct7  in  7  ID-stage funct7
  rs1_id, rs2_id, rd_id  in  RA_W each  ID-stage register fields
  branch_taken  in  1  EX-stage branch resolved taken
  addr_lo  in  log2(XLEN/8)  EX-stage address low bits
  stall_out  out  1  hold PC and IF/ID
  flush_out  out  1  squash IF/ID
  alu_ctrl  out  4  EX ALU op
  mul_sel  out  1  EX result from multiplier
  mux3_sel  out  1  EX src1 select, 1 = PC
  mux4_sel  out  1  EX src2 select, 1 = immediate
  DM_WEB  out  1  MEM write enable, active-low
  DM_BWEB  out  XLEN  MEM bit write enable, active-low
  misalign  out  1  MEM store misaligned
  wb_en  out  1  WB register write enable
  wb_rd  out  RA_W  WB destination register

Function
REQ-005 SHALL decode opcodes Rtype 0110011, Itype 0010011, Load 0000011, Store 0100011, Branch 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111, LUI 0110111; any other opcode decodes as bubble.
REQ-006 SHALL register decode into an ID/EX control register, then EX/MEM, then MEM/WB; EX outputs come from ID/EX, DM_* and misalign from EX/MEM, wb_* from MEM/WB.
REQ-007 SHALL set alu_ctrl: Rtype {funct7[5],funct3}; Itype funct3 001/101 {funct7[5],funct3}, else {0,funct3}; LUI 1001; all others 0000.
REQ-008 SHALL set mul_sel=1 for Rtype with funct7=0000001, with alu_ctrl=0000 for that instruction.
REQ-009 SHALL set mux3_sel=1 for AUIPC and JAL, else 0; mux4_sel=0 for Rtype and Branch, else 1.
REQ-010 SHALL set wb_en=0 for Branch, Store, bubbles and rd=0; otherwise 1, with wb_rd=rd.
REQ-011 SHALL define a bubble as all controls 0, DM_WEB=1, DM_BWEB all ones, wb_en=0, misalign=0.
REQ-012 SHALL assert stall_out combinationally, for one cycle, when ID/EX holds a Load with rd!=0 equal to rs1_id, or to rs2_id when ID opcode is Rtype/Store/Branch; ID/EX then loads a bubble.
REQ-013 SHALL run a multiply-busy counter: a multiply entering EX holds ID/EX MUL_LAT cycles total, stall_out=1 for the first MUL_LAT-1 of them, and EX/MEM loads a bubble on each held cycle.
REQ-014 SHALL assert flush_out combinationally when ID/EX holds JAL or JALR, or holds Branch with branch_taken=1; ID/EX then loads a bubble on the next edge.
REQ-015 SHALL give flush priority over load-use stall; flush during a multiply hold is impossible (multiply is not a branch) and needs no handling.
REQ-016 SHALL generate DM_BWEB for Store in EX/MEM (registered from EX addr_lo): SB clears the 8 bits of lane addr_lo; SH clears the 16 bits of half-lane addr_lo>>1; SW clears 32 bits of word-lane addr_lo>>2; SD (XLEN=64, funct3 011) clears all; other bits 1.
REQ-017 SHALL, for a store whose addr_lo is not a multiple of its size, assert misalign=1 and keep DM_WEB=1 and DM_BWEB all ones.
REQ-018 SHALL drive DM_WEB=0 only for an aligned Store in EX/MEM.

Reset
REQ-019 SHALL on rst load bubbles into all three pipeline registers and clear the multiply counter, immediately and regardless of clk.
REQ-020 SHALL output after reset: alu_ctrl 0000, mul_sel 0, mux3_sel 0, mux4_sel 0, DM_WEB 1, DM_BWEB all ones, misalign 0, wb_en 0, wb_rd 0, stall_out 0, flush_out 0.
REQ-021 SHALL abandon any in-progress multiply hold when rst is asserted mid-operation; the first instruction after release decodes normally.

Verification
REQ-022 SHALL check: Load rd=5 followed by add rs1=5 -> stall_out=1 one cycle, a bubble in EX, then add in EX with alu_ctrl 0000.
REQ-023 SHALL check: SB with addr_lo=2 -> one cycle later DM_WEB=0, DM_BWEB=0xFF00FFFF; SH with addr_lo=1 -> misalign=1, DM_WEB=1.
REQ-024 SHALL check: Branch in EX with branch_taken=1 -> flush_out=1 that cycle, next EX shows a bubble, wb_en=0 three cycles after the branch enters EX.
REQ-025 SHALL check: MUL_LAT=3, mul then add -> stall_out=1 for 2 cycles, mul_sel=1 for 3 cycles, two bubbles follow mul into MEM.
REQ-026 SHALL check: rst asserted during the second multiply-hold cycle -> all outputs at REQ-020 values asynchronously; an Itype srai after release gives alu_ctrl 1101.
